// File: rtl/sad_reduce_scheduler_if.sv
// Bundle between the SAD cores/controller and the reduction scheduler.
// The master side drives the core results; the slave side reports the running minimum.
interface sad_reduce_scheduler_if #(
  parameter int NUM_CORES = 8,
  parameter int SAD_W     = 32,
  parameter int POS_W     = 8
);
  logic                       start;
  logic [NUM_CORES-1:0]       core_valid;
  logic [NUM_CORES*SAD_W-1:0] core_sad;
  logic [NUM_CORES*POS_W-1:0] core_row;
  logic [NUM_CORES*POS_W-1:0] core_col;
  logic [NUM_CORES-1:0]       core_ack;
  logic [SAD_W-1:0]           min_sad;
  logic [POS_W-1:0]           min_row;
  logic [POS_W-1:0]           min_col;
  logic [2:0]                 min_core;
  logic [3:0]                 count;
  logic                       busy;
  logic                       done;

  modport master (
    output start, core_valid, core_sad, core_row, core_col,
    input  core_ack, min_sad, min_row, min_col, min_core, count, busy, done
  );

  modport slave (
    input  start, core_valid, core_sad, core_row, core_col,
    output core_ack, min_sad, min_row, min_col, min_core, count, busy, done
  );
endinterface

// File: rtl/sad_reduce_scheduler.sv
// Round-robin collector that accepts one SAD core result per cycle and keeps the
// minimum SAD with its coordinates; ties resolve to the lower core index.
module sad_reduce_scheduler #(
  parameter int NUM_CORES = 8,
  parameter int SAD_W     = 32,
  parameter int POS_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  sad_reduce_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t               state;
  logic [NUM_CORES-1:0] pending;
  logic [2:0]           rr_ptr;
  logic                 first_acc;
  logic [SAD_W-1:0]     min_sad_q;
  logic [POS_W-1:0]     min_row_q;
  logic [POS_W-1:0]     min_col_q;
  logic [2:0]           min_core_q;
  logic [3:0]           count_q;
  logic                 busy_q;
  logic                 done_q;

  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] grant_mask;
  logic [NUM_CORES-1:0] pending_nxt;
  logic                 grant_vld;
  logic [2:0]           grant_idx;
  logic [2:0]           rr_nxt;
  logic [SAD_W-1:0]     grant_sad;
  logic [POS_W-1:0]     grant_row;
  logic [POS_W-1:0]     grant_col;
  logic                 take_min;

  assign eligible = (state == COLLECT) ? (bus.core_valid & pending) : '0;

  // Search starts at the round-robin pointer and wraps modulo NUM_CORES.
  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!grant_vld && eligible[j]) begin
        grant_vld = 1'b1;
        grant_idx = 3'(j);
      end
    end
  end

  assign grant_mask  = grant_vld ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign pending_nxt = pending & ~grant_mask;
  assign rr_nxt      = (grant_idx == 3'(NUM_CORES-1)) ? 3'd0 : grant_idx + 3'd1;
  assign grant_sad   = bus.core_sad[int'(grant_idx)*SAD_W +: SAD_W];
  assign grant_row   = bus.core_row[int'(grant_idx)*POS_W +: POS_W];
  assign grant_col   = bus.core_col[int'(grant_idx)*POS_W +: POS_W];

  // The first-accept flag loads even when the first SAD equals the all-ones seed.
  assign take_min = first_acc || (grant_sad < min_sad_q) ||
                    ((grant_sad == min_sad_q) && (grant_idx < min_core_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      rr_ptr     <= '0;
      first_acc  <= 1'b0;
      min_sad_q  <= '1;
      min_row_q  <= '0;
      min_col_q  <= '0;
      min_core_q <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= COLLECT;
            pending    <= '1;
            rr_ptr     <= '0;
            first_acc  <= 1'b1;
            min_sad_q  <= '1;
            min_row_q  <= '0;
            min_col_q  <= '0;
            min_core_q <= '0;
            count_q    <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        COLLECT: begin
          if (grant_vld) begin
            pending   <= pending_nxt;
            rr_ptr    <= rr_nxt;
            count_q   <= count_q + 4'd1;
            first_acc <= 1'b0;
            if (take_min) begin
              min_sad_q  <= grant_sad;
              min_row_q  <= grant_row;
              min_col_q  <= grant_col;
              min_core_q <= grant_idx;
            end
            if (pending_nxt == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_ack = grant_mask;
  assign bus.min_sad  = min_sad_q;
  assign bus.min_row  = min_row_q;
  assign bus.min_col  = min_col_q;
  assign bus.min_core = min_core_q;
  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/sad_reduce_scheduler.md
SAD_REDUCE_SCHEDULER -- requirements
Module: sad_reduce_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8, number of SAD cores arbitrated (2..8).
REQ-002 SHALL have parameter SAD_W, default 32, SAD value width.
REQ-003 SHALL have parameter POS_W, default 8, row/column coordinate width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  one-cycle pulse; begins a reduction pass.
REQ-007 CoreValid  input  NUM_CORES  bit i high: core i result is ready.
REQ-008 CoreSAD  input  NUM_CORES*SAD_W  core i SAD at bits [i*SAD_W +: SAD_W].
REQ-009 CoreRow  input  NUM_CORES*POS_W  core i row at bits [i*POS_W +: POS_W].
REQ-010 CoreCol  input  NUM_CORES*POS_W  core i column at bits [i*POS_W +: POS_W].
REQ-011 CoreAck  output  NUM_CORES  one-hot grant; bit i high for one cycle = core i result consumed.
REQ-012 MinSAD  output  SAD_W  running/final minimum SAD.
REQ-013 MinRow, MinCol  output  POS_W each  coordinates of MinSAD.
REQ-014 MinCore  output  3  core index that supplied MinSAD.
REQ-015 Count  output  4  results accepted in current pass.
REQ-016 Busy  output  1  high in COLLECT.
REQ-017 Done  output  1  high in DONE; results stable.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-019 IDLE/DONE + Start: next cycle enter COLLECT, MinSAD=all-ones, MinRow=MinCol=0, MinCore=0, Count=0, pending mask=all NUM_CORES bits set, RR pointer=0.
REQ-020 Start while in COLLECT SHALL be ignored.
REQ-021 COLLECT: eligible = CoreValid & pending; grant the first eligible index at or after RR pointer, wrapping modulo NUM_CORES.
REQ-022 CoreAck SHALL be combinational from registered state and CoreValid, asserted only in COLLECT, at most one bit per cycle, zero when eligible is empty.
REQ-023 On grant of core g: clear pending[g], Count+=1, RR pointer=(g+1) mod NUM_CORES, all effective next edge.
REQ-024 Update Min* from core g when CoreSAD_g < MinSAD (unsigned), or CoreSAD_g == MinSAD and g < MinCore; else hold.
REQ-025 First grant of a pass SHALL always load Min* (MinSAD all-ones tie case included, via first-accept flag).
REQ-026 Latency: grant at cycle N -> Min*, Count visible at N+1; one result per cycle max throughput.
REQ-027 Grant that clears the last pending bit: enter DONE at N+1 with final Min* and Done=1 same cycle.
REQ-028 CoreValid on a core whose pending bit is clear SHALL be ignored (no ack, no update).
REQ-029 DONE SHALL hold Min*, Count, Done until Start or Rst; CoreAck=0.
REQ-030 Busy and Done SHALL never be high simultaneously.
REQ-031 No timeout: COLLECT waits indefinitely for missing cores.

Reset
REQ-032 Rst high at any edge (including mid-COLLECT) SHALL force IDLE, CoreAck=0, MinSAD=all-ones, MinRow=MinCol=0, MinCore=0, Count=0, Busy=0, Done=0, pending=0, RR pointer=0; Rst overrides Start.

Verification
REQ-033 Start, all 8 CoreValid high, SADs {50,40,30,20,35,45,55,60} -> acks cores 0..7 in consecutive cycles, Done 9 cycles after Start, MinSAD=20, MinCore=3, Count=8.
REQ-034 Start, only cores 5,2 valid, then others one per cycle later -> order 5 (if pointer reaches) per RR rule, each core acked exactly once, Count=8 at Done.
REQ-035 Tie: cores 6 and 1 both SAD=7, core 6 accepted first -> final MinCore=1, row/col of core 1.
REQ-036 Rst asserted 3 cycles into COLLECT -> next cycle all outputs at reset values; subsequent Start runs full clean pass.
REQ-037 Start during COLLECT and CoreValid held after ack -> no restart, no double ack, Count never exceeds 8.
REQ-038 All SADs = 0xFFFFFFFF -> Min* loaded from core 0 (MinCore=0), Done asserted normally.
